// File: rtl/gcm_seq_pkg.sv
// rtl/gcm_seq_pkg.sv - shared types and helpers for the GCM host sequencer
// Contents: state_t (sequencer states), BLK_BYTES, len_block(), tail_mask().
package gcm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_HK,
    S_AAD,
    S_DATA,
    S_LEN,
    S_WAIT_TAG,
    S_DONE
  } state_t;

  localparam int BLK_BYTES = 16;

  // len(A) || len(C) block: byte counts turned into 64-bit bit counts.
  function automatic logic [127:0] len_block(input logic [60:0] aad_len, input logic [60:0] pt_len);
    return {aad_len, 3'b000, pt_len, 3'b000};
  endfunction

  // Keeps the first nbytes bytes (MSB byte first); 0 means a full block.
  function automatic logic [127:0] tail_mask(input logic [3:0] nbytes);
    if (nbytes == 4'd0) return '1;
    return ~({128{1'b1}} >> {nbytes, 3'b000});
  endfunction

endpackage

// File: rtl/gcm_host_sequencer_if.sv
// rtl/gcm_host_sequencer_if.sv - host command/stream, core and status signals of the sequencer
// Modports: master = sequencer side, slave = host/core environment side.
interface gcm_host_sequencer_if #(parameter int LEN_W = 16);
  // host command
  logic             iCmd_valid, oCmd_ready, iCmd_encdec, iCmd_keylen;
  logic [255:0]     iCmd_key;
  logic [95:0]      iCmd_iv;
  logic [LEN_W-1:0] iCmd_aad_len, iCmd_pt_len;
  logic [127:0]     iCmd_tag;
  // host word stream
  logic [127:0]     iIn_data;
  logic             iIn_valid, oIn_ready;
  // core control and data
  logic             oInit, oEncdec, oOpMode, oKey_valid, oIV_valid, oKeylen;
  logic [255:0]     oKey;
  logic [95:0]      oIV;
  logic [127:0]     oAad, oBlock, oTag;
  logic             oAad_valid, oAad_last, oBlock_valid, oBlock_last, oTag_valid;
  // core results
  logic             iCore_ready, iResult_valid, iTag_valid, iAuthentic;
  logic [127:0]     iResult, iTag;
  // host results and status
  logic [127:0]     oOut_data, oTag_out;
  logic             oOut_valid, oOut_last, oDone, oAuth, oErr;

  modport master (
    input  iCmd_valid, iCmd_encdec, iCmd_keylen, iCmd_key, iCmd_iv, iCmd_aad_len, iCmd_pt_len,
           iCmd_tag, iIn_data, iIn_valid, iCore_ready, iResult, iResult_valid, iTag, iTag_valid,
           iAuthentic,
    output oCmd_ready, oIn_ready, oInit, oEncdec, oOpMode, oKey_valid, oIV_valid, oKeylen, oKey,
           oIV, oAad, oAad_valid, oAad_last, oBlock, oBlock_valid, oBlock_last, oTag, oTag_valid,
           oOut_data, oOut_valid, oOut_last, oDone, oTag_out, oAuth, oErr
  );

  modport slave (
    output iCmd_valid, iCmd_encdec, iCmd_keylen, iCmd_key, iCmd_iv, iCmd_aad_len, iCmd_pt_len,
           iCmd_tag, iIn_data, iIn_valid, iCore_ready, iResult, iResult_valid, iTag, iTag_valid,
           iAuthentic,
    input  oCmd_ready, oIn_ready, oInit, oEncdec, oOpMode, oKey_valid, oIV_valid, oKeylen, oKey,
           oIV, oAad, oAad_valid, oAad_last, oBlock, oBlock_valid, oBlock_last, oTag, oTag_valid,
           oOut_data, oOut_valid, oOut_last, oDone, oTag_out, oAuth, oErr
  );
endinterface

// File: rtl/gcm_tail_mask.sv
// rtl/gcm_tail_mask.sv - combinational 128-bit byte mask for a partial last block
// Ports: nbytes (valid bytes in block, 0 = full) -> mask (1s over kept bytes, MSB byte first).
module gcm_tail_mask
  import gcm_seq_pkg::*;
(
  input  logic [3:0]   nbytes,
  output logic [127:0] mask
);
  assign mask = tail_mask(nbytes);
endmodule

// File: rtl/gcm_host_sequencer.sv
// rtl/gcm_host_sequencer.sv - drives an aes_gcm core through one GCM message for a host
// Ports: iClk, iRstn (sync active-low), bus (gcm_host_sequencer_if.master: command, word stream,
//        core control/data, core results, host results/status).
// Build option: GCM_SEQ_TIMEOUT_EN enables the TIMEOUT-cycle watchdog; otherwise oErr is tied 0.
module gcm_host_sequencer
  import gcm_seq_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                 iClk,
  input  logic                 iRstn,
  gcm_host_sequencer_if.master bus
);
  localparam int CW = LEN_W - 3;

  function automatic logic [CW-1:0] blocks(input logic [LEN_W-1:0] n);
    logic [LEN_W:0] t;
    t = {1'b0, n} + (LEN_W+1)'(BLK_BYTES - 1);
    return t[LEN_W:4];
  endfunction

  state_t           state, state_n;
  logic             encdec_q, keylen_q, armed, ready_q, rise;
  logic [255:0]     key_q;
  logic [95:0]      iv_q;
  logic [LEN_W-1:0] aad_len_q, pt_len_q;
  logic [127:0]     ctag_q, aad_q, blk_q, tag_out_q;
  logic [CW-1:0]    na_q, nc_q, a_cnt, c_cnt, r_cnt;
  logic             aad_valid_q, aad_last_q, blk_valid_q, blk_last_q, done_q, auth_q, err_q;
  logic             in_ready, aad_issue, blk_issue, empty_issue, len_issue, res_take, issue_any;
  logic             in_last, out_last, timeout;
  logic [3:0]       in_nbytes, out_nbytes;
  logic [127:0]     in_mask, out_mask;

  assign rise      = bus.iCore_ready & ~ready_q;
  assign issue_any = aad_issue | blk_issue | empty_issue | len_issue;
  assign in_last   = (state == S_AAD) ? (a_cnt == na_q - CW'(1)) : (c_cnt == nc_q - CW'(1));
  assign out_last  = (r_cnt == nc_q - CW'(1));
  assign in_nbytes  = !in_last ? 4'd0 : ((state == S_AAD) ? aad_len_q[3:0] : pt_len_q[3:0]);
  assign out_nbytes = out_last ? pt_len_q[3:0] : 4'd0;

  gcm_tail_mask u_in_mask  (.nbytes(in_nbytes),  .mask(in_mask));
  gcm_tail_mask u_out_mask (.nbytes(out_nbytes), .mask(out_mask));

`ifdef GCM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          in_window, activity;
  assign in_window = state inside {S_WAIT_HK, S_AAD, S_DATA, S_LEN, S_WAIT_TAG};
  // Any ready edge or result/tag strobe counts as the core making progress.
  assign activity  = (bus.iCore_ready != ready_q) | bus.iResult_valid | bus.iTag_valid;
  assign timeout   = in_window && !activity && (idle_cnt == TW'(TIMEOUT - 1));
  always_ff @(posedge iClk) begin
    if (!iRstn || !in_window || activity) idle_cnt <= '0;
    else                                  idle_cnt <= idle_cnt + TW'(1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    in_ready    = 1'b0;
    aad_issue   = 1'b0;
    blk_issue   = 1'b0;
    empty_issue = 1'b0;
    len_issue   = 1'b0;
    res_take    = 1'b0;
    case (state)
      S_IDLE:    if (bus.iCmd_valid) state_n = S_START;
      S_START:   state_n = S_WAIT_HK;
      S_WAIT_HK: if (rise) state_n = (na_q != '0) ? S_AAD : S_DATA;
      S_AAD: begin
        in_ready  = armed && (a_cnt < na_q);
        aad_issue = in_ready && bus.iIn_valid;
        if (aad_issue && in_last) state_n = S_DATA;
      end
      S_DATA: begin
        if (nc_q == '0) begin
          // Empty payload: a bare last strobe tells the core there is no data.
          empty_issue = armed;
          if (armed) state_n = S_LEN;
        end else begin
          in_ready  = armed && (c_cnt < nc_q);
          blk_issue = in_ready && bus.iIn_valid;
          res_take  = bus.iResult_valid && (r_cnt < nc_q);
          if (res_take && out_last) state_n = S_LEN;
        end
      end
      S_LEN: begin
        len_issue = armed;
        if (armed) state_n = S_WAIT_TAG;
      end
      S_WAIT_TAG: if (bus.iTag_valid) state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
    if (timeout) state_n = S_IDLE;
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state <= S_IDLE;
      {encdec_q, keylen_q, armed, ready_q} <= '0;
      {key_q, iv_q, aad_len_q, pt_len_q, ctag_q} <= '0;
      {na_q, nc_q, a_cnt, c_cnt, r_cnt} <= '0;
      {aad_q, blk_q, tag_out_q} <= '0;
      {aad_valid_q, aad_last_q, blk_valid_q, blk_last_q, done_q, auth_q, err_q} <= '0;
    end else begin
      state       <= state_n;
      ready_q     <= bus.iCore_ready;
      aad_valid_q <= 1'b0;
      aad_last_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
      done_q      <= (state_n == S_DONE) | timeout;
      if (timeout) err_q <= 1'b0 | 1'b1;
      if (state inside {S_WAIT_HK, S_AAD, S_DATA, S_LEN}) armed <= (armed & ~issue_any) | rise;
      else                                                armed <= 1'b0;
      if (state == S_IDLE && bus.iCmd_valid) begin
        encdec_q  <= bus.iCmd_encdec;
        keylen_q  <= bus.iCmd_keylen;
        key_q     <= bus.iCmd_key;
        iv_q      <= bus.iCmd_iv;
        aad_len_q <= bus.iCmd_aad_len;
        pt_len_q  <= bus.iCmd_pt_len;
        ctag_q    <= bus.iCmd_tag;
        na_q      <= blocks(bus.iCmd_aad_len);
        nc_q      <= blocks(bus.iCmd_pt_len);
        {a_cnt, c_cnt, r_cnt} <= '0;
        {aad_q, blk_q, tag_out_q} <= '0;
        {auth_q, err_q} <= '0;
      end
      if (aad_issue) begin
        aad_q       <= bus.iIn_data & in_mask;
        aad_valid_q <= 1'b1;
        aad_last_q  <= in_last;
        a_cnt       <= a_cnt + CW'(1);
      end
      if (blk_issue) begin
        blk_q       <= bus.iIn_data & in_mask;
        blk_valid_q <= 1'b1;
        blk_last_q  <= in_last;
        c_cnt       <= c_cnt + CW'(1);
      end
      if (empty_issue) blk_last_q <= 1'b1;
      if (res_take)    r_cnt <= r_cnt + CW'(1);
      // The length block stays on oAad from LEN entry until the tag arrives.
      if (state == S_DATA && state_n == S_LEN) aad_q <= len_block(61'(aad_len_q), 61'(pt_len_q));
      if (len_issue) aad_valid_q <= 1'b1;
      if (state == S_WAIT_TAG && bus.iTag_valid) begin
        tag_out_q <= bus.iTag;
        auth_q    <= bus.iAuthentic & ~encdec_q;
      end
    end
  end

  assign bus.oCmd_ready   = (state == S_IDLE);
  assign bus.oIn_ready    = in_ready;
  assign bus.oInit        = state inside {S_START, S_WAIT_HK, S_AAD, S_DATA, S_LEN, S_WAIT_TAG};
  assign bus.oKey_valid   = (state == S_START);
  assign bus.oIV_valid    = (state == S_START);
  assign bus.oTag_valid   = (state == S_START);
  assign bus.oOpMode      = 1'b0;
  assign bus.oEncdec      = encdec_q;
  assign bus.oKeylen      = keylen_q;
  assign bus.oKey         = key_q;
  assign bus.oIV          = iv_q;
  assign bus.oTag         = ctag_q;
  assign bus.oAad         = aad_q;
  assign bus.oAad_valid   = aad_valid_q;
  assign bus.oAad_last    = aad_last_q;
  assign bus.oBlock       = blk_q;
  assign bus.oBlock_valid = blk_valid_q;
  assign bus.oBlock_last  = blk_last_q;
  assign bus.oOut_valid   = res_take;
  assign bus.oOut_last    = res_take & out_last;
  assign bus.oOut_data    = res_take ? (bus.iResult & out_mask) : '0;
  assign bus.oDone        = done_q;
  assign bus.oTag_out     = tag_out_q;
  assign bus.oAuth        = auth_q;
  assign bus.oErr         = err_q;
endmodule

// File: tb/tb_gcm_host_sequencer.sv
// tb/tb_gcm_host_sequencer.sv - directed self-checking bench for gcm_host_sequencer
module tb_gcm_host_sequencer;
  import gcm_seq_pkg::*;

`ifdef GCM_SEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam logic [255:0] KEY = {128'hfeffe9928665731c6d6a8f9467308308, 128'h0};
  localparam logic [95:0]  IV  = 96'hcafebabefacedbaddecaf888;
  localparam logic [127:0] TAG = 128'h5bc94fbc3221a5db94fae95ae7121a47;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [127:0] aad_in[2], aad_exp[2], pt_in[4], blk_exp[4], res_in[4], out_exp[4];

  always #5 clk = ~clk;

  gcm_host_sequencer_if #(.LEN_W(16)) bus ();
  gcm_host_sequencer #(.LEN_W(16), .TIMEOUT(TO)) dut (.iClk(clk), .iRstn(rstn), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Core ready falls for a cycle then rises, which arms the next issue.
  task automatic rearm();
    bus.iCore_ready = 1'b0;
    tick();
    bus.iCore_ready = 1'b1;
    tick();
  endtask

  task automatic send_cmd(input logic enc, input logic kl, input int alen, input int plen,
                          input logic [127:0] ctag);
    bus.iCmd_encdec  = enc;
    bus.iCmd_keylen  = kl;
    bus.iCmd_key     = KEY;
    bus.iCmd_iv      = IV;
    bus.iCmd_aad_len = 16'(alen);
    bus.iCmd_pt_len  = 16'(plen);
    bus.iCmd_tag     = ctag;
    bus.iCmd_valid   = 1'b1;
    tick();
    bus.iCmd_valid   = 1'b0;
  endtask

  task automatic run_msg(input logic enc, input logic kl, input int alen, input int plen,
                         input logic [127:0] ctag, input logic [127:0] rtag, input logic auth_in,
                         input logic auth_exp, input logic [127:0] len_exp);
    int na, nc;
    bit need_arm;
    na = (alen + 15) / 16;
    nc = (plen + 15) / 16;
    need_arm = 1'b0;
    send_cmd(enc, kl, alen, plen, ctag);
    chk1("start_init", bus.oInit, 1'b1);
    chk1("start_valids", bus.oKey_valid & bus.oIV_valid & bus.oTag_valid, 1'b1);
    chk1("start_cmd_ready", bus.oCmd_ready, 1'b0);
    chkw("start_key_hi", bus.oKey[255:128], KEY[255:128]);
    chkw("start_iv", 128'(bus.oIV), 128'(IV));
    chk1("start_encdec", bus.oEncdec, enc);
    chk1("start_keylen", bus.oKeylen, kl);
    chkw("start_tag", bus.oTag, ctag);
    rearm();
    chk1("hk_init_held", bus.oInit, 1'b1);
    chk1("hk_key_valid_drop", bus.oKey_valid, 1'b0);
    for (int i = 0; i < na; i++) begin
      if (need_arm) rearm();
      need_arm = 1'b1;
      chk1("aad_in_ready", bus.oIn_ready, 1'b1);
      bus.iIn_data  = aad_in[i];
      bus.iIn_valid = 1'b1;
      tick();
      bus.iIn_valid = 1'b0;
      chk1("aad_valid", bus.oAad_valid, 1'b1);
      chkw("aad_data", bus.oAad, aad_exp[i]);
      chk1("aad_last", bus.oAad_last, i == na - 1);
      chk1("aad_in_ready_drop", bus.oIn_ready, 1'b0);
    end
    if (nc == 0) begin
      if (need_arm) rearm();
      chk1("empty_in_ready", bus.oIn_ready, 1'b0);
      tick();
      chk1("empty_blk_valid", bus.oBlock_valid, 1'b0);
      chk1("empty_blk_last", bus.oBlock_last, 1'b1);
    end else begin
      for (int i = 0; i < nc; i++) begin
        if (need_arm) rearm();
        need_arm = 1'b1;
        bus.iIn_data  = pt_in[i];
        bus.iIn_valid = 1'b1;
        tick();
        bus.iIn_valid = 1'b0;
        chk1("blk_valid", bus.oBlock_valid, 1'b1);
        chkw("blk_data", bus.oBlock, blk_exp[i]);
        chk1("blk_last", bus.oBlock_last, i == nc - 1);
        bus.iResult       = res_in[i];
        bus.iResult_valid = 1'b1;
        #1;
        chk1("out_valid", bus.oOut_valid, 1'b1);
        chkw("out_data", bus.oOut_data, out_exp[i]);
        chk1("out_last", bus.oOut_last, i == nc - 1);
        tick();
        bus.iResult_valid = 1'b0;
      end
    end
    chkw("len_block", bus.oAad, len_exp);
    chk1("len_no_valid", bus.oAad_valid, 1'b0);
    rearm();
    tick();
    chk1("len_valid", bus.oAad_valid, 1'b1);
    chkw("len_hold", bus.oAad, len_exp);
    bus.iTag       = rtag;
    bus.iAuthentic = auth_in;
    bus.iTag_valid = 1'b1;
    tick();
    bus.iTag_valid = 1'b0;
    chk1("done_pulse", bus.oDone, 1'b1);
    chk1("done_init", bus.oInit, 1'b0);
    chkw("done_tag", bus.oTag_out, rtag);
    chk1("done_auth", bus.oAuth, auth_exp);
    chk1("done_err", bus.oErr, 1'b0);
    tick();
    chk1("idle_done_drop", bus.oDone, 1'b0);
    chk1("idle_cmd_ready", bus.oCmd_ready, 1'b1);
    chkw("idle_tag_held", bus.oTag_out, rtag);
  endtask

  initial begin
    bus.iCmd_valid = 1'b0; bus.iCmd_encdec = 1'b0; bus.iCmd_keylen = 1'b0;
    bus.iCmd_key = '0; bus.iCmd_iv = '0; bus.iCmd_aad_len = '0; bus.iCmd_pt_len = '0;
    bus.iCmd_tag = '0; bus.iIn_data = '0; bus.iIn_valid = 1'b0; bus.iCore_ready = 1'b0;
    bus.iResult = '0; bus.iResult_valid = 1'b0; bus.iTag = '0; bus.iTag_valid = 1'b0;
    bus.iAuthentic = 1'b0;
    tick();
    tick();
    chk1("rst_cmd_ready", bus.oCmd_ready, 1'b1);
    chk1("rst_init", bus.oInit, 1'b0);
    chk1("rst_in_ready", bus.oIn_ready, 1'b0);
    chk1("rst_done", bus.oDone, 1'b0);
    chkw("rst_tag_out", bus.oTag_out, 128'h0);
    chkw("rst_aad", bus.oAad, 128'h0);
    rstn = 1'b1;
    tick();

    // Encrypt, 20 AAD bytes (second block keeps 4 bytes), 64 payload bytes.
    aad_in[0]  = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    aad_exp[0] = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    aad_in[1]  = 128'habaddad2111111112222222233333333;
    aad_exp[1] = 128'habaddad2000000000000000000000000;
    pt_in[0] = 128'hd9313225f88406e5a55909c5aff5269a; blk_exp[0] = 128'hd9313225f88406e5a55909c5aff5269a;
    pt_in[1] = 128'h86a7a9531534f7da2e4c303d8a318a72; blk_exp[1] = 128'h86a7a9531534f7da2e4c303d8a318a72;
    pt_in[2] = 128'h1c3c0c95956809532fcf0e2449a6b525; blk_exp[2] = 128'h1c3c0c95956809532fcf0e2449a6b525;
    pt_in[3] = 128'hb16aedf5aa0de657ba637b391aafd255; blk_exp[3] = 128'hb16aedf5aa0de657ba637b391aafd255;
    res_in[0] = 128'h42831ec2217774244b7221b784d0d49c; out_exp[0] = 128'h42831ec2217774244b7221b784d0d49c;
    res_in[1] = 128'he3aa212f2c02a4e035c17e2329aca12e; out_exp[1] = 128'he3aa212f2c02a4e035c17e2329aca12e;
    res_in[2] = 128'h21d514b25466931c7d8f6a5aac84aa05; out_exp[2] = 128'h21d514b25466931c7d8f6a5aac84aa05;
    res_in[3] = 128'h1ba30b396a0aac973d58e091473f5985; out_exp[3] = 128'h1ba30b396a0aac973d58e091473f5985;
    run_msg(1'b1, 1'b0, 20, 64, 128'h0, TAG, 1'b1, 1'b0,
            128'h00000000_000000a0_00000000_00000200);

    // Decrypt: matching tag, then tag with bit 0 flipped (core reports not authentic).
    run_msg(1'b0, 1'b0, 20, 64, TAG, TAG, 1'b1, 1'b1,
            128'h00000000_000000a0_00000000_00000200);
    run_msg(1'b0, 1'b0, 20, 64, TAG ^ 128'h1, TAG, 1'b0, 1'b0,
            128'h00000000_000000a0_00000000_00000200);

    // Empty AAD and payload, AES-256 key length.
    run_msg(1'b1, 1'b1, 0, 0, 128'h0, 128'h58e2fccefa7e3061367f1d57a4e7455a, 1'b0, 1'b0, 128'h0);

    // 17 payload bytes: second block keeps only byte 0.
    pt_in[1]   = 128'haabbbbbbbbbbbbbbbbbbbbbbbbbbbbbb;
    blk_exp[1] = 128'haa000000000000000000000000000000;
    res_in[1]  = 128'h55cccccccccccccccccccccccccccccc;
    out_exp[1] = 128'h55000000000000000000000000000000;
    run_msg(1'b1, 1'b0, 0, 17, 128'h0, 128'h0123456789abcdef0011223344556677, 1'b0, 1'b0,
            128'h00000000_00000000_00000000_00000088);

    // Reset pulse in the middle of DATA, then a clean message.
    send_cmd(1'b1, 1'b0, 0, 32, 128'h0);
    rearm();
    bus.iIn_data  = pt_in[0];
    bus.iIn_valid = 1'b1;
    tick();
    bus.iIn_valid = 1'b0;
    chk1("pre_rst_blk_valid", bus.oBlock_valid, 1'b1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk1("mid_rst_cmd_ready", bus.oCmd_ready, 1'b1);
    chk1("mid_rst_init", bus.oInit, 1'b0);
    chk1("mid_rst_blk_valid", bus.oBlock_valid, 1'b0);
    chkw("mid_rst_blk", bus.oBlock, 128'h0);
    chkw("mid_rst_key_hi", bus.oKey[255:128], 128'h0);
    chk1("mid_rst_in_ready", bus.oIn_ready, 1'b0);
    run_msg(1'b1, 1'b0, 0, 17, 128'h0, 128'hfedcba98765432100011223344556677, 1'b0, 1'b0,
            128'h00000000_00000000_00000000_00000088);

`ifdef GCM_SEQ_TIMEOUT_EN
    begin
      int n;
      bus.iCore_ready = 1'b0;
      tick();
      send_cmd(1'b1, 1'b0, 0, 16, 128'h0);
      tick();
      n = 0;
      while (!bus.oDone && n < 40) begin
        tick();
        n++;
      end
      chkw("to_cycles", 128'(n), 128'd16);
      chk1("to_err", bus.oErr, 1'b1);
      chk1("to_init", bus.oInit, 1'b0);
      tick();
      chk1("to_cmd_ready", bus.oCmd_ready, 1'b1);
      chk1("to_err_held", bus.oErr, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
